// File: rtl/noc_pkg.sv
// Shared NoC definitions: link FSM state codes, mesh direction codes, default link sizing.
// No logic; constants, types and a counter-width helper only.
// Imported by the link transmitter and its phit mux/counter.
package noc_pkg;

  // Default link sizing
  localparam int NOC_DATA_WIDTH      = 8;
  localparam int NOC_PHIT_PER_FLIT   = 2;
  localparam int NOC_FLIT_PER_PACKET = 4;

  // Link FSM state codes, shared with the receive-side port control
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_FLIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    SEND      = ST_SEND,
    WAIT_FLIT = ST_WAIT_FLIT
  } tx_state_e;

  // Mesh port directions
  typedef enum logic [1:0] {
    DIR_NORTH = 2'd0,
    DIR_SOUTH = 2'd1,
    DIR_WEST  = 2'd2,
    DIR_EAST  = 2'd3
  } dir_e;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phit_mux_counter.sv
// Holds the flit being sent and selects its current phit; phit 0 is the LSB slice.
// Latency: load in cycle t presents phit 0 in cycle t+1; advance steps to the next phit next cycle.
// Backpressure: none internally; the caller only advances on a completed link handshake.
module phit_mux_counter
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = NOC_DATA_WIDTH,
  parameter int PhitPerFlit = NOC_PHIT_PER_FLIT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [DATA_WIDTH*PhitPerFlit-1:0] flit_in,
  input  logic                              advance,
  output logic [DATA_WIDTH-1:0]             phit_out,
  output logic                              first_phit,
  output logic                              last_phit
);

  localparam int PCW = cnt_width(PhitPerFlit);

  logic [DATA_WIDTH*PhitPerFlit-1:0] flit_reg_q, flit_reg_d;
  logic [PCW-1:0]                    phit_cnt_q, phit_cnt_d;

  assign first_phit = (phit_cnt_q == '0);
  assign last_phit  = (phit_cnt_q == PCW'(PhitPerFlit - 1));

  // Next flit register / phit counter: load restarts at phit 0, advance saturates at the last phit
  always_comb begin
    flit_reg_d = flit_reg_q;
    phit_cnt_d = phit_cnt_q;
    if (load) begin
      flit_reg_d = flit_in;
      phit_cnt_d = '0;
    end else if (advance && !last_phit) begin
      phit_cnt_d = phit_cnt_q + PCW'(1);
    end
  end

  // Flit register and phit counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_reg_q <= '0;
      phit_cnt_q <= '0;
    end else begin
      flit_reg_q <= flit_reg_d;
      phit_cnt_q <= phit_cnt_d;
    end
  end

  // Slice mux selecting the phit addressed by the counter
  always_comb begin
    phit_out = '0;
    for (int i = 0; i < PhitPerFlit; i++) begin
      if (phit_cnt_q == PCW'(i)) phit_out = flit_reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/phit_tx_serializer.sv
// Serializes flits into phits on the NoC link and frames FlitPerPacket flits per packet.
// Latency: flit loaded in cycle t drives phit 0 with valid_out in cycle t+1; zero bubble between flits.
// Backpressure: ready_out low holds the phit stable; flit_ready combinationally follows ready_out on the last phit.
// Optional: define PHIT_TX_PARITY_EN to add the phit_parity output.
module phit_tx_serializer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH    = NOC_DATA_WIDTH,
  parameter int PhitPerFlit   = NOC_PHIT_PER_FLIT,
  parameter int FlitPerPacket = NOC_FLIT_PER_PACKET
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH*PhitPerFlit-1:0] flit_in,
  input  logic                              flit_valid,
  output logic                              flit_ready,
  output logic [DATA_WIDTH-1:0]             phit_out,
  output logic                              valid_out,
  input  logic                              ready_out,
  output logic                              head_phit,
  output logic                              tail_phit,
  output logic                              busy,
  output logic                              pkt_done
`ifdef PHIT_TX_PARITY_EN
  ,
  output logic                              phit_parity
`endif
);

  localparam int FCW = cnt_width(FlitPerPacket);

  tx_state_e      state_q, state_d;
  logic [FCW-1:0] flit_cnt_q, flit_cnt_d;
  logic           pkt_done_q, pkt_done_d;
  logic           load, advance, hs;
  logic           first_phit, last_phit, last_flit;

  phit_mux_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PhitPerFlit(PhitPerFlit)
  ) u_phit_mux_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .flit_in   (flit_in),
    .advance   (advance),
    .phit_out  (phit_out),
    .first_phit(first_phit),
    .last_phit (last_phit)
  );

  assign valid_out = (state_q == SEND);
  assign hs        = valid_out & ready_out;
  assign last_flit = (flit_cnt_q == FCW'(FlitPerPacket - 1));
  assign head_phit = valid_out & first_phit & (flit_cnt_q == '0);
  assign tail_phit = valid_out & last_phit & last_flit;
  assign busy      = (state_q != IDLE);
  assign pkt_done  = pkt_done_q;

`ifdef PHIT_TX_PARITY_EN
  // Parity follows phit_out, so it inherits the link stability rule and its reset value of 0
  assign phit_parity = ^phit_out;
`endif

  // Next-state, flit counter and flit-load control
  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    pkt_done_d = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    flit_ready = 1'b0;
    case (state_q)
      IDLE: begin
        flit_ready = 1'b1;
        if (flit_valid) begin
          load       = 1'b1;
          flit_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Accept the next flit in the same cycle the last phit leaves
        flit_ready = ready_out & last_phit;
        if (hs) begin
          if (!last_phit) begin
            advance = 1'b1;
          end else if (!last_flit) begin
            if (flit_valid) begin
              load       = 1'b1;
              flit_cnt_d = flit_cnt_q + FCW'(1);
            end else begin
              state_d = WAIT_FLIT;
            end
          end else begin
            pkt_done_d = 1'b1;
            if (flit_valid) begin
              load       = 1'b1;
              flit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      WAIT_FLIT: begin
        flit_ready = 1'b1;
        if (flit_valid) begin
          load       = 1'b1;
          flit_cnt_d = flit_cnt_q + FCW'(1);
          state_d    = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, flit counter and packet-done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flit_cnt_q <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

endmodule
